// File: rtl/sram_io_reader_pkg.sv
// Shared definitions for the SRAM serial read-back path: state encoding, default widths
// and the counter-width helper.
package sram_io_reader_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAddrWidth = 9;

  typedef enum logic [2:0] {
    RdIdle = 3'd0,
    RdAddr = 3'd1,
    RdRead = 3'd2,
    RdCapt = 3'd3,
    RdShft = 3'd4,
    RdDone = 3'd5
  } rd_state_e;

  // The counter must hold both AW-1 and DW-1; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned aw, int unsigned dw);
    int unsigned m;
    m = (aw > dw) ? aw : dw;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sram_io_shreg.sv
// Right-shift register with async clear, serial-in at the MSB, parallel load and
// serial-out from the LSB. Parallel load takes priority over shifting.
module sram_io_shreg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_data,
  input  logic             shift,
  input  logic             si,
  output logic             so,
  output logic [Width-1:0] q
);

  logic [Width-1:0] reg_q, reg_d;

  always_comb begin
    reg_d = reg_q;
    if (load) begin
      reg_d = load_data;
    end else if (shift) begin
      if (Width > 1) begin
        reg_d = {si, reg_q[Width-1:1]};
      end else begin
        reg_d = si;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign so = reg_q[0];
  assign q  = reg_q;

endmodule

// File: rtl/sram_io_reader.sv
// Serial SRAM read-back: shifts an address in on SI, reads the SRAM, and shifts the word
// out LSB-first on SO. Holding LOAD_N low at the end of a word bursts to the next address.
module sram_io_reader
  import sram_io_reader_pkg::*;
#(
  parameter int unsigned MEMORY_DATA_WIDTH = DefDataWidth,
  parameter int unsigned MEMORY_ADDR_WIDTH = DefAddrWidth
) (
  input  logic                         CLK,
  input  logic                         BGN,
  input  logic                         SI,
  input  logic                         LOAD_N,
  input  logic [MEMORY_DATA_WIDTH-1:0] PI,
  output logic                         CEN,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic                         SO,
  output logic                         DVLD,
  output logic                         RDY
);

  localparam int unsigned DW   = MEMORY_DATA_WIDTH;
  localparam int unsigned AW   = MEMORY_ADDR_WIDTH;
  localparam int unsigned CntW = cnt_width(AW, DW);

  rd_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            addr_shift, addr_load;
  logic [AW-1:0]   addr_q, addr_next;
  logic            dat_shift, dat_load;
  logic            dat_so;
  logic [DW-1:0]   dat_unused_q;
  logic            addr_unused_so;

  // State register
  always_ff @(posedge CLK or negedge BGN) begin
    if (!BGN) begin
      state_q <= RdIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RdIdle: begin
        if (!LOAD_N) begin
          state_d = RdAddr;
          cnt_d   = CntW'(AW - 1);
        end
      end
      RdAddr: begin
        if (cnt_q == '0) begin
          state_d = RdRead;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RdRead: state_d = RdCapt;
      RdCapt: begin
        state_d = RdShft;
        cnt_d   = CntW'(DW - 1);
      end
      RdShft: begin
        if (cnt_q == '0) begin
          state_d = LOAD_N ? RdDone : RdRead;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RdDone:  state_d = RdDone;
      default: state_d = RdIdle;
    endcase
  end

  // Datapath control; the address increment wraps naturally at 2^AW.
  always_comb begin
    addr_shift = (state_q == RdAddr);
    addr_load  = (state_q == RdShft) && (cnt_q == '0) && !LOAD_N;
    addr_next  = addr_q + AW'(1);
    dat_load   = (state_q == RdCapt);
    dat_shift  = (state_q == RdShft);
  end

  sram_io_shreg #(
    .Width(AW)
  ) u_addr_reg (
    .clk      (CLK),
    .rst_n    (BGN),
    .load     (addr_load),
    .load_data(addr_next),
    .shift    (addr_shift),
    .si       (SI),
    .so       (addr_unused_so),
    .q        (addr_q)
  );

  sram_io_shreg #(
    .Width(DW)
  ) u_dat_reg (
    .clk      (CLK),
    .rst_n    (BGN),
    .load     (dat_load),
    .load_data(PI),
    .shift    (dat_shift),
    .si       (1'b0),
    .so       (dat_so),
    .q        (dat_unused_q)
  );

  // Outputs decode registered state only
  always_comb begin
    CEN  = 1'b0;
    A    = '0;
    SO   = 1'b0;
    DVLD = 1'b0;
    RDY  = 1'b0;
    unique case (state_q)
      RdRead, RdCapt: begin
        CEN = 1'b1;
        A   = addr_q;
      end
      RdShft: begin
        SO   = dat_so;
        DVLD = 1'b1;
      end
      RdDone:  RDY = 1'b1;
      default: ;
    endcase
  end

endmodule
